// File: rtl/game_draw_arbiter.sv
// game_draw_arbiter: sequences paddle/AI/ball draw engines once per frame
// and muxes the granted client's pixel stream onto the single VGA port.
//
// Ports:
//   clk, resetn       clock, synchronous active-low reset
//   frame_tick        one-cycle request for a draw round
//   client_en[2:0]    per-client enable
//   done_in[2:0]      per-client done level
//   x_in/y_in/colour_in/plot_in  packed client pixel streams
//   go_out[2:0]       per-client start request
//   x_out/y_out/colour_out/plot_out  registered VGA write port
//   busy, round_done  round status
//   timeout_flag[2:0] sticky per-client abort flags
//   overrun           sticky; a tick arrived with one already queued
module game_draw_arbiter #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd16000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        frame_tick,
  input  logic [2:0]  client_en,
  input  logic [2:0]  done_in,
  input  logic [23:0] x_in,
  input  logic [20:0] y_in,
  input  logic [8:0]  colour_in,
  input  logic [2:0]  plot_in,
  output logic [2:0]  go_out,
  output logic [7:0]  x_out,
  output logic [6:0]  y_out,
  output logic [2:0]  colour_out,
  output logic        plot_out,
  output logic        busy,
  output logic        round_done,
  output logic [2:0]  timeout_flag,
  output logic        overrun
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_NEXT = 2'd3;

  logic [1:0]  state;
  logic [1:0]  grant;
  logic        pending;
  logic [23:0] cnt;

  logic        start_ok;
  logic [1:0]  start_idx;
  logic        next_ok;
  logic [1:0]  next_idx;

  logic [7:0]  sel_x;
  logic [6:0]  sel_y;
  logic [2:0]  sel_colour;
  logic        sel_plot;
  logic        sel_done;
  logic        expired;

  // Lowest enabled client overall, and lowest enabled above the grant.
  // Descending scan so the last hit (lowest index) wins.
  always_comb begin
    start_ok  = 1'b0;
    start_idx = 2'd0;
    next_ok   = 1'b0;
    next_idx  = grant;
    for (int i = 2; i >= 0; i--) begin
      if (client_en[i]) begin
        start_ok  = 1'b1;
        start_idx = 2'(i);
      end
      if (client_en[i] && (i > int'(grant))) begin
        next_ok  = 1'b1;
        next_idx = 2'(i);
      end
    end
  end

  always_comb begin
    sel_x      = 8'd0;
    sel_y      = 7'd0;
    sel_colour = 3'd0;
    sel_plot   = 1'b0;
    sel_done   = 1'b0;
    case (grant)
      2'd0: begin
        sel_x      = x_in[7:0];
        sel_y      = y_in[6:0];
        sel_colour = colour_in[2:0];
        sel_plot   = plot_in[0];
        sel_done   = done_in[0];
      end
      2'd1: begin
        sel_x      = x_in[15:8];
        sel_y      = y_in[13:7];
        sel_colour = colour_in[5:3];
        sel_plot   = plot_in[1];
        sel_done   = done_in[1];
      end
      2'd2: begin
        sel_x      = x_in[23:16];
        sel_y      = y_in[20:14];
        sel_colour = colour_in[8:6];
        sel_plot   = plot_in[2];
        sel_done   = done_in[2];
      end
      default: ;
    endcase
  end

  assign expired = (cnt == TIMEOUT_CYCLES - 24'd1);
  assign busy    = (state != S_IDLE);

  always_comb begin
    go_out = 3'b000;
    if (state == S_ARM)
      go_out[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= S_IDLE;
      grant        <= 2'd0;
      pending      <= 1'b0;
      cnt          <= 24'd0;
      x_out        <= 8'd0;
      y_out        <= 7'd0;
      colour_out   <= 3'd0;
      plot_out     <= 1'b0;
      round_done   <= 1'b0;
      timeout_flag <= 3'b000;
      overrun      <= 1'b0;
    end else begin
      round_done <= 1'b0;

      if (busy && frame_tick) begin
        if (pending) overrun <= 1'b1;
        pending <= 1'b1;
      end

      if (state == S_ARM || state == S_RUN) begin
        x_out      <= sel_x;
        y_out      <= sel_y;
        colour_out <= sel_colour;
        plot_out   <= sel_plot;
      end else begin
        plot_out <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          // The round_done cycle only queues a tick; the round it
          // requests starts on the next IDLE cycle.
          if (round_done) begin
            if (frame_tick) begin
              if (pending) overrun <= 1'b1;
              pending <= 1'b1;
            end
          end else if (frame_tick || pending) begin
            pending <= 1'b0;
            if (start_ok) begin
              grant <= start_idx;
              cnt   <= 24'd0;
              state <= S_ARM;
            end else begin
              round_done <= 1'b1;
            end
          end
        end
        S_ARM, S_RUN: begin
          if (expired) begin
            timeout_flag[grant] <= 1'b1;
            state <= S_NEXT;
          end else begin
            cnt <= cnt + 24'd1;
            if (state == S_ARM && !sel_done)
              state <= S_RUN;
            else if (state == S_RUN && sel_done)
              state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (next_ok) begin
            grant <= next_idx;
            cnt   <= 24'd0;
            state <= S_ARM;
          end else begin
            round_done <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
